// File: rtl/mem_cmd_host.sv
// rtl/mem_cmd_host.sv - UART command initiator for the on-chip memory tester
// Optional read-response watchdog: define MEM_CMD_HOST_TIMEOUT_EN.
module mem_cmd_host #(
  parameter int SAMPLE  = 105,
  parameter int TIMEOUT = 4096
) (
  input  logic       i_clk,
  input  logic       i_nrst,
  input  logic       i_req_valid,
  output logic       o_req_ready,
  input  logic       i_req_we,
  input  logic [1:0] i_req_sel,
  input  logic [9:0] i_req_addr,
  input  logic [7:0] i_req_wdata,
  output logic       o_rsp_valid,
  output logic [7:0] o_rsp_rdata,
  output logic       o_rsp_err,
  output logic       o_busy,
  output logic       o_tx,
  input  logic       i_rx
);
  localparam int CW = (SAMPLE < 1) ? 1 : $clog2(SAMPLE + 1);
  localparam logic [CW-1:0] C_LAST = CW'(SAMPLE);
  localparam logic [CW-1:0] C_HALF = CW'(SAMPLE / 2);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SEND    = 2'd1;
  localparam logic [1:0] ST_WAIT_RX = 2'd2;
  localparam logic [1:0] ST_RESP    = 2'd3;

  logic [1:0]    r_state;
  logic          r_we;
  logic [1:0]    r_sel;
  logic [9:0]    r_addr;
  logic [7:0]    r_wdata;
  logic [2:0]    r_idx;
  logic [3:0]    r_bit;
  logic [CW-1:0] r_cnt;
  logic          r_rx_s1, r_rx_s2, r_rx_busy;
  logic [3:0]    r_rx_bit;
  logic [CW-1:0] r_rx_cnt;
  logic [7:0]    r_rx_sh;
  logic [7:0]    r_rdata;
  logic          r_err;

  logic [3:0]  w_we_cmd, w_re_cmd;
  logic [7:0]  w_byte;
  logic [10:0] w_frame;
  logic [2:0]  w_last;
  logic        w_rx, w_bit_end, w_rx_valid_start, w_rx_done, w_timeout;

  always_comb begin
    w_we_cmd = 4'h6;
    w_re_cmd = 4'h7;
    case (r_sel)
      2'd1: begin w_we_cmd = 4'h8; w_re_cmd = 4'h9; end
      2'd2: begin w_we_cmd = 4'hA; w_re_cmd = 4'hB; end
      default: ;
    endcase
  end

  always_comb begin
    w_byte = 8'h00;
    case (r_idx)
      3'd0: w_byte = {2'b00, r_addr[9:8], 4'h4};
      3'd1: w_byte = {r_addr[7:4], 4'h4};
      3'd2: w_byte = {r_addr[3:0], 4'h4};
      3'd3: w_byte = r_we ? {r_wdata[7:4], 4'h1} : {4'h0, w_re_cmd};
      3'd4: w_byte = r_we ? {r_wdata[3:0], 4'h1} : 8'h00;
      3'd5: w_byte = {4'h0, w_we_cmd};
      default: w_byte = 8'h00;
    endcase
  end

  // Frame bit 0 is the start bit, bits 9..10 the two stop bits.
  assign w_frame   = {2'b11, w_byte, 1'b0};
  assign w_last    = r_we ? 3'd5 : 3'd4;
  assign w_bit_end = (r_cnt == C_LAST);
  assign w_rx      = r_rx_s2;
  assign w_rx_valid_start = r_rx_busy && (r_rx_bit == 4'd0) && (r_rx_cnt == C_HALF) && !w_rx;
  assign w_rx_done = r_rx_busy && (r_rx_bit == 4'd9) && (r_rx_cnt == C_LAST);

`ifdef MEM_CMD_HOST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_to_cnt;

  // Watchdog only advances while hunting for a start bit.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst)                                    r_to_cnt <= '0;
    else if (r_state != ST_WAIT_RX || w_rx_valid_start) r_to_cnt <= '0;
    else if (!r_rx_busy)                            r_to_cnt <= r_to_cnt + 1'b1;
  end
  assign w_timeout = (r_state == ST_WAIT_RX) && !r_rx_busy && (r_to_cnt == TW'(TIMEOUT - 1));
`else
  assign w_timeout = (TIMEOUT < 0);
`endif

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state <= ST_IDLE;
      r_we    <= 1'b0;
      r_sel   <= 2'd0;
      r_addr  <= 10'd0;
      r_wdata <= 8'd0;
      r_idx   <= 3'd0;
      r_bit   <= 4'd0;
      r_cnt   <= '0;
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rdata <= 8'd0;
      r_err   <= 1'b0;
    end else begin
      r_rx_s1 <= i_rx;
      r_rx_s2 <= r_rx_s1;
      case (r_state)
        ST_IDLE: begin
          if (i_req_valid) begin
            r_we    <= i_req_we;
            r_sel   <= i_req_sel;
            r_addr  <= i_req_addr;
            r_wdata <= i_req_wdata;
            r_idx   <= 3'd0;
            r_bit   <= 4'd0;
            r_cnt   <= '0;
            r_state <= ST_SEND;
          end
        end
        ST_SEND: begin
          r_cnt <= w_bit_end ? '0 : r_cnt + 1'b1;
          if (w_bit_end) begin
            if (r_bit == 4'd10) begin
              r_bit <= 4'd0;
              if (r_idx == w_last) begin
                r_idx <= 3'd0;
                if (r_we) begin
                  r_err   <= 1'b0;
                  r_state <= ST_RESP;
                end else begin
                  r_state <= ST_WAIT_RX;
                end
              end else begin
                r_idx <= r_idx + 1'b1;
              end
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end
        end
        ST_WAIT_RX: begin
          if (w_rx_done) begin
            r_rdata <= r_rx_sh;
            r_err   <= !w_rx;
            r_state <= ST_RESP;
          end else if (w_timeout) begin
            r_rdata <= 8'hFF;
            r_err   <= 1'b1;
            r_state <= ST_RESP;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_rx_busy <= 1'b0;
      r_rx_bit  <= 4'd0;
      r_rx_cnt  <= '0;
      r_rx_sh   <= 8'd0;
    end else if (r_state != ST_WAIT_RX) begin
      r_rx_busy <= 1'b0;
      r_rx_bit  <= 4'd0;
      r_rx_cnt  <= '0;
    end else if (!r_rx_busy) begin
      if (!w_rx) begin
        r_rx_busy <= 1'b1;
        r_rx_bit  <= 4'd0;
        r_rx_cnt  <= '0;
      end
    end else if (r_rx_bit == 4'd0) begin
      if (r_rx_cnt == C_HALF) begin
        r_rx_cnt <= '0;
        if (w_rx) r_rx_busy <= 1'b0;
        else      r_rx_bit  <= 4'd1;
      end else begin
        r_rx_cnt <= r_rx_cnt + 1'b1;
      end
    end else if (r_rx_cnt == C_LAST) begin
      r_rx_cnt <= '0;
      if (r_rx_bit != 4'd9) begin
        r_rx_sh  <= {w_rx, r_rx_sh[7:1]};
        r_rx_bit <= r_rx_bit + 1'b1;
      end
    end else begin
      r_rx_cnt <= r_rx_cnt + 1'b1;
    end
  end

  assign o_req_ready = (r_state == ST_IDLE);
  assign o_busy      = !o_req_ready;
  assign o_rsp_valid = (r_state == ST_RESP);
  assign o_rsp_rdata = r_rdata;
  assign o_rsp_err   = r_err;
  assign o_tx        = (r_state == ST_SEND) ? w_frame[r_bit] : 1'b1;
endmodule
